// File: rtl/neuron_accumulator_pkg.sv
// Shared arithmetic helpers for the neuron accumulator: signed saturation and ReLU
// on a wide intermediate type. Module-specific widths are derived inside the top.
package neuron_accumulator_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Clip a wide signed value into the range of a w-bit two's-complement word
  function automatic wide_t sat_s(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic wide_t relu(input wide_t v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Aligns issue_valid with the datapath result by delaying it DEPTH cycles.
// DEPTH=0 degenerates to a wire.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH:0] vld_pipe;
      assign vld_pipe[0] = d;
      always_ff @(posedge clk) begin
        if (rst) vld_pipe[DEPTH:1] <= '0;
        else     vld_pipe[DEPTH:1] <= vld_pipe[DEPTH-1:0];
      end
      assign q = vld_pipe[DEPTH];
    end
  endgenerate

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates TERMS aligned datapath results into one neuron, applies optional ReLU,
// rescales/saturates to N bits and holds the result in a valid/ready output register.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int N     = 16,
  parameter int PIPE  = 2,
  parameter int TERMS = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 0,
  parameter int RELU  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic signed [N-1:0]          Y,
  input  logic                         co,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [N-1:0]          out_data,
  output logic                         out_sat,
  output logic                         out_co_any,
  output logic                         err_drop,
  output logic [$clog2(TERMS+1)-1:0]   term_cnt
);

  localparam int CW = $clog2(TERMS + 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  logic  term_valid;
  acc_t  acc;
  logic  sat_flag, co_flag;
  wide_t y_w, sum_w, acc_nxt, fin_w, shf_w, nar_w;
  logic  clip_acc, clip_n, last;

  valid_delay_line #(.DEPTH(PIPE)) u_dly (
    .clk (clk),
    .rst (rst),
    .d   (issue_valid),
    .q   (term_valid)
  );

  // acc_nxt doubles as the completion sum, so TERMS=1 naturally yields sext(Y)
  always_comb begin
    y_w      = wide_t'(Y);
    sum_w    = wide_t'(acc) + y_w;
    acc_nxt  = y_w;
    clip_acc = 1'b0;
    if (term_cnt != '0) begin
      acc_nxt  = sat_s(sum_w, ACC_W);
      clip_acc = (acc_nxt != sum_w);
    end
    fin_w  = (RELU != 0) ? relu(acc_nxt) : acc_nxt;
    shf_w  = fin_w >>> SHIFT;
    nar_w  = sat_s(shf_w, N);
    clip_n = (nar_w != shf_w);
    last   = (term_cnt == CW'(TERMS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      term_cnt   <= '0;
      sat_flag   <= 1'b0;
      co_flag    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      out_co_any <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      if (term_valid) begin
        acc <= acc_nxt[ACC_W-1:0];
        if (last) begin
          term_cnt <= '0;
          sat_flag <= 1'b0;
          co_flag  <= 1'b0;
        end else begin
          term_cnt <= term_cnt + CW'(1);
          sat_flag <= sat_flag | clip_acc;
          co_flag  <= co_flag | co;
        end
      end
      // A held, unconsumed result wins; the new neuron is dropped and flagged
      if (term_valid && last) begin
        if (out_valid && !out_ready) begin
          err_drop <= 1'b1;
        end else begin
          out_valid  <= 1'b1;
          out_data   <= nar_w[N-1:0];
          out_sat    <= sat_flag | clip_acc | clip_n;
          out_co_any <= co_flag | co;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench: three accumulator variants (base, RELU=0, SHIFT=2) fed through a modelled
// 2-cycle datapath; table vectors plus hand sequences, checked via a scoreboard queue.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic issue_valid;
  logic signed [15:0] iss_y;
  logic iss_co;
  logic out_ready;

  logic p1_v = 1'b0, p2_v = 1'b0;
  logic signed [15:0] p1_y = '0, p2_y = '0;
  logic p1_c = 1'b0, p2_c = 1'b0;
  logic signed [15:0] dp_y;
  logic dp_co;

  logic ov0, ov1, ov2, os0, os1, os2, oc0, oc1, oc2, ed0, ed1, ed2;
  logic signed [15:0] od0, od1, od2;
  logic [2:0] tc0, tc1, tc2;

  int total = 0;
  int bad   = 0;
  logic sb_on = 1'b0;

  typedef struct {
    int d0; int s0; int d1; int s1; int d2; int s2; int co;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int y[4]; logic [3:0] c; exp_t e;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  // Stand-in for the datapath: 2-cycle latency, garbage on non-valid cycles
  always @(posedge clk) begin
    p1_v <= issue_valid; p1_y <= iss_y; p1_c <= iss_co;
    p2_v <= p1_v;        p2_y <= p1_y;  p2_c <= p1_c;
  end
  assign dp_y  = p2_v ? p2_y : 16'sh7FFF;
  assign dp_co = p2_v ? p2_c : 1'b1;

  neuron_accumulator #(.N(16), .PIPE(2), .TERMS(4), .ACC_W(24), .SHIFT(0), .RELU(1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .Y(dp_y), .co(dp_co),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0),
    .out_co_any(oc0), .err_drop(ed0), .term_cnt(tc0));

  neuron_accumulator #(.N(16), .PIPE(2), .TERMS(4), .ACC_W(24), .SHIFT(0), .RELU(0)) dut_nr (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .Y(dp_y), .co(dp_co),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1),
    .out_co_any(oc1), .err_drop(ed1), .term_cnt(tc1));

  neuron_accumulator #(.N(16), .PIPE(2), .TERMS(4), .ACC_W(24), .SHIFT(2), .RELU(1)) dut_sh (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .Y(dp_y), .co(dp_co),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2),
    .out_co_any(oc2), .err_drop(ed2), .term_cnt(tc2));

  task automatic chk(input string n, input logic signed [63:0] a, input logic signed [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  task automatic issue(input int y, input logic c);
    issue_valid = 1'b1;
    iss_y       = 16'(y);
    iss_co      = c;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input logic [3:0] cm, input int d0, input int s0,
                              input int d1, input int s1, input int d2, input int s2,
                              input int coa);
    vec_t v;
    v.y[0] = a; v.y[1] = b; v.y[2] = c; v.y[3] = d;
    v.c = cm;
    v.e = '{d0: d0, s0: s0, d1: d1, s1: s1, d2: d2, s2: s2, co: coa};
    return v;
  endfunction

  // Scoreboard: every neuron that appears is matched against the oldest expectation
  always @(negedge clk) begin
    if (sb_on && ov0) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out got=%0d exp=none", od0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_base", od0, e.d0);
        chk("sat_base",  os0, e.s0);
        chk("co_base",   oc0, e.co);
        chk("valid_norelu", ov1, 1);
        chk("data_norelu",  od1, e.d1);
        chk("sat_norelu",   os1, e.s1);
        chk("valid_shift",  ov2, 1);
        chk("data_shift",   od2, e.d2);
        chk("sat_shift",    os2, e.s2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    tbl[0] = mk(10, 20, 30, 40, 4'b0000, 100, 0, 100, 0, 25, 0, 0);
    tbl[1] = mk(-50, 10, 10, 10, 4'b0000, 0, 0, -20, 0, 0, 0, 0);
    tbl[2] = mk(32767, 32767, 32767, 32767, 4'b0000, 32767, 1, 32767, 1, 32767, 0, 0);
    tbl[3] = mk(1, 2, 3, 4, 4'b0100, 10, 0, 10, 0, 2, 0, 1);
    tbl[4] = mk(-32768, -32768, -32768, -32768, 4'b0000, 0, 0, -32768, 1, 0, 0, 0);
    tbl[5] = mk(-100, -100, 300, 0, 4'b0000, 100, 0, 100, 0, 25, 0, 0);
    tbl[6] = mk(1000, -1, -1, -1, 4'b0001, 997, 0, 997, 0, 249, 0, 1);
    tbl[7] = mk(-7, -7, -7, -7, 4'b1111, 0, 0, -28, 0, 0, 0, 1);

    rst = 1'b1; issue_valid = 1'b0; iss_y = '0; iss_co = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", ov0, 0);
    chk("rst_data",  od0, 0);
    chk("rst_cnt",   tc0, 0);
    chk("rst_drop",  ed0, 0);
    chk("rst_sat",   os0, 0);
    chk("rst_co",    oc0, 0);
    rst = 1'b0;

    // Basic sum with latency measurement
    sb_on = 1'b1;
    sb.push_back(tbl[0].e);
    for (int t = 0; t < 4; t++) issue(tbl[0].y[t], tbl[0].c[t]);
    n = 0;
    while (!ov0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);
    @(negedge clk);
    chk("valid_cleared", ov0, 0);
    drain();

    // Table vectors issued back-to-back at full rate
    for (int v = 0; v < 8; v++) begin
      sb.push_back(tbl[v].e);
      for (int t = 0; t < 4; t++) issue(tbl[v].y[t], tbl[v].c[t]);
    end
    drain();

    // Backpressure: second neuron lost while the first is held
    sb_on = 1'b0;
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) issue(1, 1'b0);
    for (int t = 0; t < 4; t++) issue(2, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_valid", ov0, 1);
    chk("bp_data",  od0, 4);
    chk("bp_drop",  ed0, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed", ov0, 0);
    chk("bp_drop_sticky", ed0, 1);

    // Reset with two terms accepted and two still in flight
    for (int t = 0; t < 4; t++) issue(100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cnt",   tc0, 0);
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_drop",  ed0, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_quiet", ov0, 0);

    sb_on = 1'b1;
    sb.push_back('{d0: 4, s0: 0, d1: 4, s1: 0, d2: 1, s2: 0, co: 1});
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (p2_v) begin
        chk("term_cnt_seq", tc0, k);
        k++;
      end
      if (cyc < 4) begin
        issue_valid = 1'b1; iss_y = 16'sd1; iss_co = (cyc == 1);
      end else begin
        issue_valid = 1'b0; iss_co = 1'b0;
      end
      @(negedge clk);
    end
    chk("term_cnt_wrap", tc0, 0);
    chk("term_seen", k, 4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
